fifo_reader: RTL and testbench
==============================

Name: fifo_reader

Overview:
- Consumer-side controller that drains one fifo instance and presents its words to a downstream stage over a valid/ready handshake.
- Issues Fifo_rd only when the fifo reports data and permits popping (can_pop). Issued reads are tracked through the fixed read latency.
- Returned words are absorbed in a local skid buffer, so downstream back-pressure never loses data.
- Reads the fifo dropped (no valid_read at the expected slot) are counted.

Parameters:
- BITNUMBER, 6, data word width; matches the fifo.
- RD_LAT, 2, cycles from Fifo_rd asserted to the corresponding valid_read/Fifo_Data_out; legal range 1..4.
- SKID_DEPTH, 4, skid buffer entries; must be >= RD_LAT+1; power of two.
- CNT_W, 8, width of the statistics counters.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; all state is cleared while low.
- enable  in  1  1 = drain the fifo; 0 = stop issuing reads and flush.
- Fifo_empty  in  1  fifo empty flag.
- can_pop  in  1  fifo flow-control permission to pop.
- valid_read  in  1  fifo read-data valid strobe.
- Fifo_Data_out  in  BITNUMBER  fifo read data; sampled only when valid_read=1.
- Fifo_rd  out  1  pop request to the fifo; registered.
- data_out  out  BITNUMBER  head of the skid buffer.
- valid_out  out  1  data_out valid.
- ready_in  in  1  downstream accepts data_out this cycle.
- busy  out  1  reads in flight or skid buffer non-empty.
- state  out  2  FSM state: IDLE=0, RUN=1, FLUSH=2.
- words_cnt  out  CNT_W  words delivered downstream; wraps.
- drop_cnt  out  CNT_W  issued reads with no valid_read returned; saturates at all-ones.
- ovf_err  out  1  sticky: valid_read arrived with the skid buffer full.

Behaviour:
- Reset (reset=0, async):
  - Fifo_rd=0, valid_out=0, data_out=0, busy=0, state=IDLE, words_cnt=0, drop_cnt=0, ovf_err=0.
  - In-flight shift register and skid pointers/occupancy cleared.
  - Reset asserted mid-operation discards in-flight and buffered words without recording drops.
- In-flight tracking:
  - RD_LAT-bit shift register `infl`; bit 0 is loaded with the registered Fifo_rd each cycle and shifted toward bit RD_LAT-1.
  - The bit leaving position RD_LAT-1 marks the cycle in which valid_read is expected.
  - If that bit is 1 and valid_read=0, drop_cnt increments (saturating).
  - A valid_read with no expected slot is still captured if space allows; it is not an error.
- Issue rule, evaluated combinationally and registered into Fifo_rd:
  - issue = (state==RUN) & !Fifo_empty & can_pop & (occ + popcount(infl) + Fifo_rd < SKID_DEPTH).
  - The issue rule guarantees that no legal return overflows the buffer.
- Skid buffer:
  - Circular buffer of SKID_DEPTH entries. Write on valid_read; read on valid_out & ready_in.
  - Simultaneous write and read leave occ unchanged. Pointers wrap modulo SKID_DEPTH.
  - valid_out = (occ != 0). data_out is the entry at the read pointer (combinational from the buffer); data_out = 0 when empty.
  - valid_read with occ==SKID_DEPTH and no simultaneous pop: word discarded, ovf_err set until reset.
  - Buffer-to-output latency: a word captured at edge N is visible on data_out/valid_out after edge N, i.e. one cycle after valid_read.
- words_cnt increments on each valid_out & ready_in; wraps modulo 2^CNT_W.
- busy = (occ != 0) | (infl != 0) | Fifo_rd.
- FSM:
  - IDLE -> RUN when enable=1.
  - RUN -> FLUSH when enable=0. Fifo_rd is forced 0 from the next edge.
  - FLUSH -> IDLE when infl==0 and Fifo_rd==0, i.e. all returns have landed.
  - FLUSH -> RUN if enable returns to 1 before that.
  - The skid buffer keeps draining downstream in every state.
- Widths: occ needs log2(SKID_DEPTH)+1 bits; the issue comparison is done at that width plus 1 to avoid wrap.

Test Plan:
- Basic drain: enable=1, fifo preloaded with 0x01..0x04, ready_in=1, RD_LAT=2 -> Fifo_rd high 4 cycles; data_out 0x01..0x04 in order; words_cnt=4; drop_cnt=0; ovf_err=0.
- Back-pressure: ready_in=0 with data available -> at most SKID_DEPTH=4 reads issued; occ saturates at 4 with no ovf_err. Release ready_in -> all 4 delivered in order, then reading resumes.
- Flow control: can_pop toggled 0 for 5 cycles mid-stream -> Fifo_rd stays 0 throughout; no words lost or duplicated across the gap.
- Dropped read: Fifo_rd issued, but the bench withholds valid_read at slot RD_LAT -> drop_cnt=1; FLUSH still reaches IDLE.
- Flush: enable dropped with 2 reads in flight -> state=FLUSH; both words captured and delivered; state=IDLE 2 cycles later; busy=0 once occ=0.
- Reset mid-stream: reset asserted with occ=3 -> all outputs zero immediately (async); after release, state=IDLE and counters=0.

Source files
------------

// File: rtl/fifo_reader_if.sv
`default_nettype none
// ============================================================================
// Module  : fifo_reader_if
// Brief   : fifo-side and downstream handshake bundle for fifo_reader.
// Revision: 1.0 - initial release
// ============================================================================
interface fifo_reader_if #(
  parameter int BITNUMBER = 6
);
  logic                 Fifo_empty;
  logic                 can_pop;
  logic                 valid_read;
  logic [BITNUMBER-1:0] Fifo_Data_out;
  logic                 Fifo_rd;
  logic [BITNUMBER-1:0] data_out;
  logic                 valid_out;
  logic                 ready_in;

  modport master (
    output Fifo_rd, data_out, valid_out,
    input  Fifo_empty, can_pop, valid_read, Fifo_Data_out, ready_in
  );

  modport slave (
    input  Fifo_rd, data_out, valid_out,
    output Fifo_empty, can_pop, valid_read, Fifo_Data_out, ready_in
  );
endinterface
`default_nettype wire

// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
// Module  : fifo_reader
// Brief   : drains a fifo through a fixed-latency read path into a skid buffer
//           and hands words downstream over valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_reader #(
  parameter int BITNUMBER  = 6,
  parameter int RD_LAT     = 2,
  parameter int SKID_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  fifo_reader_if.master    bus,
  output logic             busy,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] words_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             ovf_err
);

  localparam int c_ptr_w = $clog2(SKID_DEPTH);
  localparam int c_occ_w = c_ptr_w + 1;
  localparam int c_sum_w = c_occ_w + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_fifo_rd;
  logic [RD_LAT-1:0]    r_infl;
  logic [RD_LAT-1:0]    w_infl_next;
  logic [BITNUMBER-1:0] r_mem [SKID_DEPTH];
  logic [c_ptr_w-1:0]   r_wptr;
  logic [c_ptr_w-1:0]   r_rptr;
  logic [c_occ_w-1:0]   r_occ;
  logic [CNT_W-1:0]     r_words;
  logic [CNT_W-1:0]     r_drops;
  logic                 r_ovf;

  logic [c_sum_w-1:0]   w_infl_cnt;
  logic [c_sum_w-1:0]   w_sum;
  logic                 w_issue;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_expect;

  // Bit 0 takes the current pop request; the top bit marks the return slot.
  if (RD_LAT == 1) begin : g_infl_lat1
    assign w_infl_next = r_fifo_rd;
  end else begin : g_infl_shift
    assign w_infl_next = {r_infl[RD_LAT-2:0], r_fifo_rd};
  end

  always_comb begin
    w_infl_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_infl_cnt = w_infl_cnt + c_sum_w'(r_infl[i]);
    end
  end

  // Outstanding words (buffered + in flight + this cycle's pop) must fit the buffer.
  assign w_sum    = c_sum_w'(r_occ) + w_infl_cnt + c_sum_w'(r_fifo_rd);
  assign w_issue  = (r_state == S_RUN) & ~bus.Fifo_empty & bus.can_pop &
                    (w_sum < c_sum_w'(SKID_DEPTH));

  assign w_full   = (r_occ == c_occ_w'(SKID_DEPTH));
  assign w_pop    = (r_occ != '0) & bus.ready_in;
  assign w_push   = bus.valid_read & (~w_full | w_pop);
  assign w_expect = r_infl[RD_LAT-1];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_next = S_RUN;
      S_RUN:   if (!enable) w_state_next = S_FLUSH;
      S_FLUSH: begin
        if (enable)
          w_state_next = S_RUN;
        else if ((r_infl == '0) && !r_fifo_rd)
          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_fifo_rd <= 1'b0;
      r_infl    <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_occ     <= '0;
      r_words   <= '0;
      r_drops   <= '0;
      r_ovf     <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_state   <= w_state_next;
      r_fifo_rd <= w_issue;
      r_infl    <= w_infl_next;
      if (w_push) begin
        r_mem[r_wptr] <= bus.Fifo_Data_out;
        r_wptr        <= r_wptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rptr  <= r_rptr + c_ptr_w'(1);
        r_words <= r_words + CNT_W'(1);
      end
      if (w_push && !w_pop)
        r_occ <= r_occ + c_occ_w'(1);
      else if (!w_push && w_pop)
        r_occ <= r_occ - c_occ_w'(1);
      if (bus.valid_read && w_full && !w_pop)
        r_ovf <= 1'b1;
      if (w_expect && !bus.valid_read && (r_drops != '1))
        r_drops <= r_drops + CNT_W'(1);
    end
  end

  assign bus.Fifo_rd   = r_fifo_rd;
  assign bus.valid_out = (r_occ != '0);
  assign bus.data_out  = (r_occ != '0) ? r_mem[r_rptr] : '0;
  assign busy          = (r_occ != '0) | (r_infl != '0) | r_fifo_rd;
  assign state         = r_state;
  assign words_cnt     = r_words;
  assign drop_cnt      = r_drops;
  assign ovf_err       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_reader
// Brief   : directed bench with a fixed-latency fifo model and an in-order
//           scoreboard of words returned by the fifo.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_reader;

  localparam int BW         = 6;
  localparam int RD_LAT     = 2;
  localparam int SKID_DEPTH = 4;
  localparam int CNT_W      = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             busy;
  logic [1:0]       state;
  logic [CNT_W-1:0] words_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             ovf_err;

  fifo_reader_if #(.BITNUMBER(BW)) bus();

  fifo_reader #(
    .BITNUMBER (BW),
    .RD_LAT    (RD_LAT),
    .SKID_DEPTH(SKID_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .bus      (bus.master),
    .busy     (busy),
    .state    (state),
    .words_cnt(words_cnt),
    .drop_cnt (drop_cnt),
    .ovf_err  (ovf_err)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [BW-1:0] fifo_q[$];
  logic [BW-1:0] sb[$];
  logic          pv [RD_LAT];
  logic [BW-1:0] pd [RD_LAT];
  int          exp_total;
  int          exp_drop;
  int          rd_cycles;
  bit          skip_next;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_empty();
    int avail;
    avail = fifo_q.size() - ((bus.Fifo_rd === 1'b1) ? 1 : 0);
    bus.Fifo_empty = (avail <= 0);
  endtask

  task automatic push_words(input int base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(BW'(base + i));
    set_empty();
  endtask

  task automatic clear_pipe();
    for (int i = 0; i < RD_LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    bus.valid_read    = 1'b0;
    bus.Fifo_Data_out = '0;
  endtask

  // One clock: sample pre-edge handshakes, then advance the fifo model.
  task automatic tick();
    logic          p_rd;
    logic          p_pop;
    logic [BW-1:0] p_dat;
    logic [BW-1:0] w;
    p_rd  = bus.Fifo_rd;
    p_pop = bus.valid_out & bus.ready_in;
    p_dat = bus.data_out;
    @(posedge clk);
    #1;
    if (p_rd === 1'b1) rd_cycles++;
    if (p_pop === 1'b1 && reset === 1'b1) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) chk("data_order", 32'(p_dat), 32'(sb.pop_front()));
    end
    for (int i = RD_LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = 1'b0;
    pd[0] = '0;
    if (p_rd === 1'b1 && reset === 1'b1 && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      if (skip_next) begin
        skip_next = 1'b0;
        exp_drop++;
      end else begin
        pv[0] = 1'b1;
        pd[0] = w;
      end
    end
    bus.valid_read = pv[RD_LAT-1];
    if (pv[RD_LAT-1]) begin
      bus.Fifo_Data_out = pd[RD_LAT-1];
      sb.push_back(pd[RD_LAT-1]);
      exp_total++;
    end else begin
      bus.Fifo_Data_out = BW'($urandom);
    end
    set_empty();
  endtask

  function automatic bit pipe_busy();
    bit b = 1'b0;
    for (int i = 0; i < RD_LAT; i++) b |= pv[i];
    return b;
  endfunction

  task automatic wait_drained(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      tick();
      done = (fifo_q.size() == 0) && (sb.size() == 0) && (busy === 1'b0) && !pipe_busy();
    end
    chk(tag, 32'(done), 1);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] s);
    for (int i = 0; i < 30 && state !== s; i++) tick();
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic check_zero_outputs(input string pfx);
    chk({pfx, "_fifo_rd"},   32'(bus.Fifo_rd),   0);
    chk({pfx, "_valid_out"}, 32'(bus.valid_out), 0);
    chk({pfx, "_data_out"},  32'(bus.data_out),  0);
    chk({pfx, "_busy"},      32'(busy),          0);
    chk({pfx, "_state"},     32'(state),         0);
    chk({pfx, "_words"},     32'(words_cnt),     0);
    chk({pfx, "_drops"},     32'(drop_cnt),      0);
    chk({pfx, "_ovf"},       32'(ovf_err),       0);
  endtask

  initial begin
    bit seen;
    reset            = 1'b0;
    enable           = 1'b0;
    bus.can_pop      = 1'b1;
    bus.ready_in     = 1'b1;
    bus.Fifo_empty   = 1'b1;
    exp_total        = 0;
    exp_drop         = 0;
    rd_cycles        = 0;
    skip_next        = 1'b0;
    clear_pipe();
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset = 1'b1;
    tick();

    // Basic drain of four preloaded words.
    rd_cycles = 0;
    push_words(1, 4);
    enable = 1'b1;
    wait_drained("basic_drained");
    chk("basic_rd_cycles", 32'(rd_cycles), 4);
    chk("basic_words",     32'(words_cnt), 4);
    chk("basic_drops",     32'(drop_cnt),  0);
    chk("basic_ovf",       32'(ovf_err),   0);
    chk("basic_state_run", 32'(state),     1);

    // Back-pressure: outstanding reads capped at the skid depth.
    rd_cycles    = 0;
    bus.ready_in = 1'b0;
    push_words(6'h10, 8);
    repeat (15) tick();
    chk("bp_rd_cycles", 32'(rd_cycles),     SKID_DEPTH);
    chk("bp_valid",     32'(bus.valid_out), 1);
    chk("bp_head",      32'(bus.data_out),  32'h10);
    chk("bp_ovf",       32'(ovf_err),       0);
    bus.ready_in = 1'b1;
    wait_drained("bp_drained");
    chk("bp_rd_total", 32'(rd_cycles), 8);
    chk("bp_words",    32'(words_cnt), 32'(exp_total & 8'hFF));

    // Flow control gap: no pops while can_pop is low.
    push_words(6'h20, 10);
    repeat (3) tick();
    bus.can_pop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("gap_fifo_rd", 32'(bus.Fifo_rd), 0);
    end
    bus.can_pop = 1'b1;
    wait_drained("gap_drained");
    chk("gap_words", 32'(words_cnt), 32'(exp_total & 8'hFF));

    // Dropped read: the fifo withholds one return.
    skip_next = 1'b1;
    push_words(6'h2C, 3);
    wait_drained("drop_drained");
    chk("drop_cnt",   32'(drop_cnt),  32'(exp_drop));
    chk("drop_words", 32'(words_cnt), 32'(exp_total & 8'hFF));
    enable = 1'b0;
    wait_state("drop_idle", 2'd0);

    // Flush with reads in flight.
    enable = 1'b1;
    push_words(6'h30, 6);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = (bus.Fifo_rd === 1'b1);
    end
    chk("flush_rd_seen", 32'(seen), 1);
    tick();
    enable = 1'b0;
    tick();
    chk("flush_state", 32'(state), 2);
    wait_state("flush_idle", 2'd0);
    for (int i = 0; i < 20 && (busy !== 1'b0 || pipe_busy()); i++) tick();
    chk("flush_busy",  32'(busy),      0);
    chk("flush_sb",    32'(sb.size()), 0);
    chk("flush_words", 32'(words_cnt), 32'(exp_total & 8'hFF));
    chk("flush_ovf",   32'(ovf_err),   0);
    fifo_q.delete();
    set_empty();

    // Asynchronous reset with words parked in the skid buffer.
    enable       = 1'b1;
    bus.ready_in = 1'b0;
    push_words(6'h38, 3);
    repeat (12) tick();
    chk("rst_pre_valid", 32'(bus.valid_out), 1);
    chk("rst_pre_head",  32'(bus.data_out),  32'h38);
    #2;
    reset = 1'b0;
    #1;
    check_zero_outputs("rst_mid");
    sb.delete();
    fifo_q.delete();
    clear_pipe();
    exp_total = 0;
    exp_drop  = 0;
    enable    = 1'b0;
    set_empty();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("rst_post_state", 32'(state),         0);
    chk("rst_post_words", 32'(words_cnt),     0);
    chk("rst_post_drops", 32'(drop_cnt),      0);
    chk("rst_post_valid", 32'(bus.valid_out), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
